// File: rtl/pci_target_mem_if.sv
// pci_target_mem_if -- PCI target-side bus signals shared between an
// initiator (master modport) and the target memory (slave modport).
//
// Signals:
//   frame_n, irdy_n  initiator FRAME# / IRDY#, active-low
//   c_be_n[3:0]      command in the address phase, byte enables (active-low)
//                    in data phases
//   devsel_n         target device select, active-low
//   trdy_n           target ready, active-low
//   stop_n           target disconnect request, active-low
//   dbg_state[3:0]   target FSM state, for observation only
//   ad_oe            high while the target drives the AD bus
//
// Handshake: a data phase completes on a rising clk edge where irdy_n=0 and
// trdy_n=0 are both sampled; either side may hold its ready high to stall,
// and while stalled address, data and the opposite ready stay unchanged.
// The AD bus itself is a separate inout port on the target.
interface pci_target_mem_if;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] c_be_n;
    logic       devsel_n;
    logic       trdy_n;
    logic       stop_n;
    logic [3:0] dbg_state;
    logic       ad_oe;

    modport master (
        output frame_n, irdy_n, c_be_n,
        input  devsel_n, trdy_n, stop_n, dbg_state, ad_oe
    );

    modport slave (
        input  frame_n, irdy_n, c_be_n,
        output devsel_n, trdy_n, stop_n, dbg_state, ad_oe
    );
endinterface

// File: rtl/pci_target_mem.sv
// pci_target_mem -- PCI memory-read / memory-write target backed by a
// 2^ADDR_BITS x 32-bit word memory mapped at BASE_ADDR.
//
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   asynchronous active-low reset (memory contents are kept)
//   bus   pci_target_mem_if.slave: frame_n, irdy_n, c_be_n in;
//         devsel_n, trdy_n, stop_n, dbg_state, ad_oe out
//   ad    32-bit multiplexed address/data bus (inout)
//
// Bursts increment the word address after every completed data phase.
// A burst that would run past the last word is disconnected (stop_n=0)
// instead of wrapping. Misses sit in BUSY until the bus goes idle.
module pci_target_mem #(
    parameter int          ADDR_BITS   = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    pci_target_mem_if.slave     bus,
    inout  wire  [31:0]         ad
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        DECODE = 4'd1,
        WAIT   = 4'd2,
        WDATA  = 4'd3,
        RTA    = 4'd4,
        RDATA  = 4'd5,
        DISC   = 4'd6,
        TURN   = 4'd7,
        BUSY   = 4'd8
    } state_t;

    localparam int unsigned    DEPTH   = 1 << ADDR_BITS;
    // Loaded on entry to WAIT; WAIT exits when the counter reads zero, so it
    // lasts exactly WAIT_STATES cycles.
    localparam logic [1:0]     WS_LOAD = 2'(WAIT_STATES - 1);
    localparam logic [ADDR_BITS-1:0] WA_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t      state;
    logic [31:2] addr_q;
    logic [3:0]  cmd_q;
    logic [1:0]  wait_cnt;
    logic [31:0] ad_q;
    logic        ad_oe;
    logic        devsel_r;
    logic        trdy_r;
    logic        stop_r;

    logic [31:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] word_addr;
    logic [ADDR_BITS-1:0] wa_next;
    logic                 last_word;
    logic                 hit;
    logic [31:0]          rd_word;
    logic [31:0]          next_word;

    assign word_addr = addr_q[ADDR_BITS+1:2];
    assign wa_next   = word_addr + WA_ONE;
    assign last_word = &word_addr;
    assign rd_word   = mem[word_addr];
    assign next_word = mem[wa_next];
    assign hit       = ((cmd_q == 4'b0110) || (cmd_q == 4'b0111)) &&
                       (addr_q[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);

    assign ad            = ad_oe ? ad_q : 32'bz;
    assign bus.devsel_n  = devsel_r;
    assign bus.trdy_n    = trdy_r;
    assign bus.stop_n    = stop_r;
    assign bus.ad_oe     = ad_oe;
    assign bus.dbg_state = state;

    // Memory kept out of the reset domain so reset never touches contents.
    always_ff @(posedge clk) begin
        if (state == WDATA && !bus.irdy_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus.c_be_n[b]) begin
                    mem[word_addr][8*b +: 8] <= ad[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            cmd_q    <= '0;
            wait_cnt <= '0;
            ad_q     <= '0;
            ad_oe    <= 1'b0;
            devsel_r <= 1'b1;
            trdy_r   <= 1'b1;
            stop_r   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.frame_n) begin
                        addr_q <= ad[31:2];
                        cmd_q  <= bus.c_be_n;
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    if (!hit) begin
                        state <= BUSY;
                    end else begin
                        devsel_r <= 1'b0;
                        if (!cmd_q[0]) begin
                            state <= RTA;
                        end else if (WAIT_STATES == 0) begin
                            state  <= WDATA;
                            trdy_r <= 1'b0;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WS_LOAD;
                        end
                    end
                end
                RTA: begin
                    // Turnaround cycle: initiator releases AD, target not yet driving.
                    if (WAIT_STATES == 0) begin
                        state  <= RDATA;
                        trdy_r <= 1'b0;
                        ad_oe  <= 1'b1;
                        ad_q   <= rd_word;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WS_LOAD;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        trdy_r <= 1'b0;
                        if (cmd_q[0]) begin
                            state <= WDATA;
                        end else begin
                            state <= RDATA;
                            ad_oe <= 1'b1;
                            ad_q  <= rd_word;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                WDATA, RDATA: begin
                    if (!bus.irdy_n) begin
                        addr_q[ADDR_BITS+1:2] <= wa_next;
                        if (bus.frame_n) begin
                            state    <= TURN;
                            devsel_r <= 1'b1;
                            trdy_r   <= 1'b1;
                            ad_oe    <= 1'b0;
                        end else if (last_word) begin
                            state  <= DISC;
                            trdy_r <= 1'b1;
                            stop_r <= 1'b0;
                        end else if (state == RDATA) begin
                            // Prefetch the next word so it is on AD for the next phase.
                            ad_q <= next_word;
                        end
                    end
                end
                DISC: begin
                    if (bus.frame_n) begin
                        state    <= TURN;
                        devsel_r <= 1'b1;
                        stop_r   <= 1'b1;
                        ad_oe    <= 1'b0;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                BUSY: begin
                    if (bus.frame_n && bus.irdy_n) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pci_target_mem.md
PCI_TARGET_MEM -- requirements
Module: pci_target_mem

Interface
REQ-001 SHALL have parameter: ADDR_BITS, 8, log2 of memory depth in 32-bit words (depth = 2^ADDR_BITS).
REQ-002 SHALL have parameter: BASE_ADDR, 32'h0000_1000, byte base address of the window; bits [ADDR_BITS+1:0] are ignored.
REQ-003 SHALL have parameter: WAIT_STATES, 0, number of wait cycles (0..3) inserted before the first data phase of every burst.
REQ-004 SHALL have port: clk  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: frame_n  in  1  initiator FRAME#, active-low.
REQ-007 SHALL have port: irdy_n  in  1  initiator ready, active-low.
REQ-008 SHALL have port: c_be_n  in  4  command in address phase, byte enables (active-low) in data phases.
REQ-009 SHALL have port: ad  inout  32  multiplexed address/data bus.
REQ-010 SHALL have port: devsel_n  out  1  device select, active-low.
REQ-011 SHALL have port: trdy_n  out  1  target ready, active-low.
REQ-012 SHALL have port: stop_n  out  1  target disconnect request, active-low.

Function
REQ-013 SHALL use states IDLE, DECODE, WAIT, WDATA, RTA, RDATA, DISC, TURN, BUSY; the state register SHALL be the only state-holding element besides address, wait counter, the ad output register and the memory.
REQ-014 IDLE: when frame_n=0 is sampled, SHALL latch ad as address and c_be_n as command, then go to DECODE.
REQ-015 DECODE: hit = (cmd 4'b0110 read or 4'b0111 write) and latched addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]; hit SHALL go to RTA (read) or WAIT (write); miss SHALL go to BUSY.
REQ-016 devsel_n SHALL be low from the cycle after DECODE up to and including the final data phase of a hit; it SHALL never assert on a miss.
REQ-017 Read: RTA SHALL last exactly one cycle, with ad undriven; ad SHALL be driven from RDATA onward. After WAIT_STATES further cycles, go to RDATA, with trdy_n=0.
REQ-018 Write: WAIT SHALL hold trdy_n=1 for WAIT_STATES cycles (zero cycles if 0), then enter WDATA with trdy_n=0.
REQ-019 Transfer: a data phase SHALL complete only on an edge where irdy_n=0 and trdy_n=0; irdy_n=1 SHALL stall with address, data and trdy_n held.
REQ-020 Write transfer: SHALL update only byte lanes whose c_be_n bit is 0; c_be_n=4'hF SHALL write nothing but still count as a transfer.
REQ-021 Read transfer: ad SHALL carry mem[word_addr] (combinational array read, registered onto ad); byte enables SHALL be ignored.
REQ-022 word_addr SHALL be latched addr[ADDR_BITS+1:2] and SHALL increment by 1 after every completed transfer.
REQ-023 Last data phase: a transfer completed with frame_n=1 SHALL be the final one; next state TURN.
REQ-024 Wrap: a transfer completed at word_addr = 2^ADDR_BITS-1 with frame_n=0 SHALL NOT wrap; go to DISC with stop_n=0 and trdy_n=1 until frame_n=1 is sampled, then TURN.
REQ-025 TURN: one cycle with devsel_n, trdy_n and stop_n driven 1 and ad released, then IDLE.
REQ-026 BUSY (miss): all outputs inactive; return to IDLE when frame_n=1 and irdy_n=1 are sampled together.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, devsel_n=1, trdy_n=1, stop_n=1, ad undriven, word_addr=0 and wait counter=0, including mid-burst.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-029 Write burst at 0x1000, cmd 0111, 4 words 0xA0..0xA3, irdy_n low throughout -> 4 transfers, devsel_n low 4 cycles, mem[0..3] = 0xA0..0xA3.
REQ-030 Read burst at 0x1004, cmd 0110, 3 words -> 1 turnaround cycle with ad=Z, then ad = mem[1], mem[2], mem[3] on successive transfers; TURN after the third.
REQ-031 Write 0xDEADBEEF with c_be_n=4'b1010 over 0x11223344 -> memory word 0x11AD33EF.
REQ-032 Burst starting at word 0xFE with frame_n held low -> 2 transfers, then stop_n=0 and trdy_n=1 until frame_n=1, then TURN, then IDLE.
REQ-033 Read to 0x2000 and I/O read (cmd 0010) to 0x1000 -> devsel_n stays 1 and ad is never driven; IDLE reached after the bus goes idle.
REQ-034 WAIT_STATES=2, irdy_n toggling, rst pulsed low mid-burst -> first trdy_n=0 two cycles late, stalls hold data, reset releases all outputs the same cycle.
